adder_tree_accumulator: RTL and testbench
=========================================

Name: adder_tree_accumulator

Overview:
- Downstream stage of the 2-level adder tree top. It consumes the registered tree output `sum` (ADDER_WIDTH+1 bits, unsigned) one sample per cycle.
- It accumulates ACC_LEN consecutive samples into a frame total and presents that total on a valid/ready result port.
- A result held by downstream backpressures the sample input.
- An optional flush closes a partial frame early.

Parameters:
- ADDER_WIDTH, 24, operand width of the tree leaves.
- IN_EXTRA, 1, extra bits on the incoming tree sum. Sample width is IN_W = ADDER_WIDTH+IN_EXTRA.
- ACC_LEN, 16, samples per frame. Must be ≥2; need not be a power of 2.
- CNT_W, $clog2(ACC_LEN+1), width of the sample counter and of out_count.
- ACC_W, IN_W+$clog2(ACC_LEN), accumulator and result width. This width is overflow-free by construction.

Ports:
- clk  in  1  rising-edge clock, the single clock domain
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_sum carries a sample this cycle
- in_sum  in  IN_W  unsigned tree sum
- in_ready  out  1  block accepts a sample this cycle
- flush  in  1  close the current frame early; qualified by in_ready
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACC_W  frame total, zero-extended arithmetic
- out_count  out  CNT_W  number of samples in the frame (1..ACC_LEN)

Behaviour:
- Reset:
  - Synchronous, active-high, wins over all other inputs.
  - Clears acc, cnt, out_sum, out_count and out_valid to 0. in_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-frame or while out_valid is high discards all partial and pending data, with no output pulse.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational).
  - A sample is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - out_sum and out_count are stable while out_valid && !out_ready.
- States (implicit in cnt/out_valid):
  - ACCUM: out_valid=0.
  - HOLD: out_valid=1, waiting for out_ready.
  - A transfer with a simultaneous frame close is back-to-back: out_valid stays 1 and the new result loads.
- Accumulation, per accepted sample:
  - acc_next = acc + zero_ext(in_sum). cnt increments.
  - Frame close condition: (cnt+1 == ACC_LEN), or flush with an accepted sample.
  - On close: out_sum <= acc_next, out_count <= cnt+1, out_valid <= 1, acc <= 0, cnt <= 0.
- Flush without an accepted sample (in_ready=1, and in_valid=0 or the sample was not accepted):
  - If cnt>0: out_sum <= acc, out_count <= cnt, out_valid <= 1, and acc/cnt clear.
  - If cnt==0: no effect, and no empty frame is emitted.
- Flush while in_ready=0: ignored. The source must hold flush until in_ready.
- Latency: the closing sample accepted in cycle N gives out_valid=1 with the total in cycle N+1.
- Throughput: one sample per cycle while out_ready is held high, including across frame boundaries.
- out_valid clears the cycle after a transfer unless a new frame closes in that same transfer cycle.
- Arithmetic is unsigned modulo 2^ACC_W. It cannot wrap for ≤ ACC_LEN samples of max value.
- X on in_sum while in_valid=0 must not propagate to acc.

Test Plan:
1. ACC_LEN=4: feed 1,2,3,4 on consecutive cycles with out_ready=1 → one cycle after sample 4, out_valid=1, out_sum=10, out_count=4. out_valid drops the next cycle.
2. ACC_LEN=4, max operand: 4 samples of 0x1FFFFFF → out_sum=0x7FFFFFC (27-bit), with no wrap.
3. Backpressure: hold out_ready=0 after a frame closes → in_ready=0. Samples presented during the hold are not absorbed, and out_sum is stable for 5 cycles. Raising out_ready gives a transfer, and in_ready=1 in the same cycle.
4. Back-to-back: 8 continuous samples of value 5 with out_ready=1, ACC_LEN=4 → two results, each out_sum=20 and count 4, with no bubble on in_ready.
5. Flush:
   - Samples 7,9, then flush with in_valid=0 → out_sum=16, out_count=2.
   - A flush with cnt=0 → no out_valid.
   - Flush together with sample 3 after samples 7,9 → out_sum=19, out_count=3.
6. Reset mid-frame: after samples 1,2, assert rst for 1 cycle → out_valid stays 0. The next frame 1,1,1,1 gives out_sum=4 (the earlier partial is discarded).

Source files
------------

// File: rtl/adder_tree_accumulator.sv
// adder_tree_accumulator: sums ACC_LEN tree samples per frame
// and emits each frame total on a valid/ready result port.
module adder_tree_accumulator #(
  parameter int ADDER_WIDTH = 24,
  parameter int IN_EXTRA    = 1,
  parameter int ACC_LEN     = 16,
  parameter int IN_W        = ADDER_WIDTH + IN_EXTRA,
  parameter int CNT_W       = $clog2(ACC_LEN + 1),
  parameter int ACC_W       = IN_W + $clog2(ACC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             xfer;
  logic             close_smp;
  logic             close_fl;

  // Handshake qualifiers and frame-close decode.
  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    acc_add   = acc + ACC_W'(in_sum);
    cnt_inc   = cnt + CNT_W'(1);
    close_smp = accept &&
                ((cnt_inc == CNT_W'(ACC_LEN)) || flush);
    close_fl  = in_ready && flush && !accept &&
                (cnt != '0);
  end

  // Accumulator, counter and held result; a close in the
  // transfer cycle overrides the out_valid clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
      end
      if (close_smp) begin
        out_sum   <= acc_add;
        out_count <= cnt_inc;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else if (close_fl) begin
        out_sum   <= acc;
        out_count <= cnt;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else if (accept) begin
        acc <= acc_add;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// tb_adder_tree_accumulator: directed checks of the frame
// accumulator with ACC_LEN=4.
module tb_adder_tree_accumulator;

  localparam int AW  = 24;
  localparam int IE  = 1;
  localparam int AL  = 4;
  localparam int IW  = AW + IE;
  localparam int CW  = $clog2(AL + 1);
  localparam int OW  = IW + $clog2(AL);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_sum;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic [CW-1:0] out_count;

  int n_chk;
  int n_fail;

  adder_tree_accumulator #(
    .ADDER_WIDTH(AW),
    .IN_EXTRA(IE),
    .ACC_LEN(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_sum(in_sum),
    .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [IW-1:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // 1,2,3,4 -> 10
    feed(1);
    feed(2);
    feed(3);
    chk("t1_mid_valid", 64'(out_valid), 64'd0);
    feed(4);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_sum", 64'(out_sum), 64'd10);
    chk("t1_count", 64'(out_count), 64'd4);
    in_valid = 1'b0;
    tick();
    chk("t1_drop", 64'(out_valid), 64'd0);

    // max operands, no wrap
    for (int i = 0; i < 4; i++) feed(25'h1FFFFFF);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_sum", 64'(out_sum), 64'h7FFFFFC);

    // backpressure hold
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("t3_ready_lo", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      feed(100);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_sum", 64'(out_sum), 64'h7FFFFFC);
      chk("t3_hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t3_ready_hi", 64'(in_ready), 64'd1);
    tick();
    chk("t3_xfer", 64'(out_valid), 64'd0);

    // back-to-back frames of 5s
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sum   = 5;
      #1;
      chk("t4_ready", 64'(in_ready), 64'd1);
      tick();
      if (i == 3 || i == 7) begin
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_sum", 64'(out_sum), 64'd20);
        chk("t4_count", 64'(out_count), 64'd4);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t4_drop", 64'(out_valid), 64'd0);

    // flush with no sample
    feed(7);
    feed(9);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5a_valid", 64'(out_valid), 64'd1);
    chk("t5a_sum", 64'(out_sum), 64'd16);
    chk("t5a_count", 64'(out_count), 64'd2);
    tick();
    chk("t5a_drop", 64'(out_valid), 64'd0);

    // flush on empty frame
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5b_empty", 64'(out_valid), 64'd0);

    // flush with sample
    feed(7);
    feed(9);
    flush = 1'b1;
    feed(3);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5c_valid", 64'(out_valid), 64'd1);
    chk("t5c_sum", 64'(out_sum), 64'd19);
    chk("t5c_count", 64'(out_count), 64'd3);
    tick();
    chk("t5c_drop", 64'(out_valid), 64'd0);

    // reset mid-frame
    feed(1);
    feed(2);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    in_sum = 'x;
    tick();
    chk("t6_idle_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) feed(1);
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_sum", 64'(out_sum), 64'd4);
    chk("t6_count", 64'(out_count), 64'd4);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
